// File: rtl/hazard_controller.sv
// Hazard and stall sequencer for the 5-stage F/D/E/M/W pipeline.
// Forwarding, load-use/PC-write stalls, flushes and a memory-wait FSM.
module hazard_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       Ra1D,
   input  logic [3:0]       Ra2D,
   input  logic [3:0]       Ra1E,
   input  logic [3:0]       Ra2E,
   input  logic [3:0]       WA3E,
   input  logic [3:0]       WA3M,
   input  logic [3:0]       WA3W,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             PCSrcD,
   input  logic             PCSrcE,
   input  logic             PCSrcM,
   input  logic             PCSrcW,
   input  logic             BranchTakenE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             MemErr,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO = TW'(MEM_TIMEOUT);
   localparam logic [TW-1:0] ONE = TW'(1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t        state;
   logic [TW-1:0] cnt;
   logic          ldr;
   logic          pcw;
   logic          mstall;

   function automatic logic [1:0] fwd(
      input logic [3:0] ra,
      input logic [3:0] wam,
      input logic [3:0] waw,
      input logic       wem,
      input logic       wew
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (wem && ra == wam && ra != 4'd15)
         sel = 2'b10;
      else if (wew && ra == waw && ra != 4'd15)
         sel = 2'b01;
      return sel;
   endfunction

   always_comb begin
      ldr = MemtoRegE & (Ra1D == WA3E | Ra2D == WA3E);
      pcw = PCSrcD | PCSrcE | PCSrcM;
      if (state == S_WAIT)
         mstall = !MemReadyM & (cnt != TMO);
      else
         mstall = MemReqM & !MemReadyM;
   end

   // Reset forces every stage to a bubble and drops all stalls.
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
      if (!reset) begin
         ForwardAE = fwd(Ra1E, WA3M, WA3W, RegWriteM, RegWriteW);
         ForwardBE = fwd(Ra2E, WA3M, WA3W, RegWriteM, RegWriteW);
         StallF    = ldr | pcw | mstall;
         StallD    = ldr | mstall;
         StallE    = mstall;
         StallM    = mstall;
         FlushD    = !mstall & (pcw | PCSrcW | BranchTakenE);
         FlushE    = !mstall & (ldr | BranchTakenE);
         FlushW    = mstall;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         MemErr     <= 1'b0;
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (state == S_IDLE) begin
            if (MemReqM && !MemReadyM) begin
               state <= S_WAIT;
               cnt   <= ONE;
            end
         end else begin
            // Ready on the timeout cycle still counts as a completed access.
            if (MemReadyM) begin
               state <= S_IDLE;
            end else if (cnt == TMO) begin
               state  <= S_IDLE;
               MemErr <= 1'b1;
            end else begin
               cnt <= cnt + ONE;
            end
         end
         if (StallF && StallCount != '1)
            StallCount <= StallCount + 1'b1;
         if (FlushE && FlushCount != '1)
            FlushCount <= FlushCount + 1'b1;
      end
   end

endmodule
